// File: rtl/fb_pkg.sv
// Shared types and helpers for the frame-buffer pixel fetch stage.
package fb_pkg;

    localparam int unsigned FB_ADDR_W = 17;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } pixel565_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel888_t;

    // Timing/control that travels alongside a pixel while its BRAM read is in flight.
    typedef struct packed {
        logic        live;
        logic [10:0] hcount;
        logic [9:0]  vcount;
        logic        hsync;
        logic        vsync;
        logic        active;
        logic        valid;
    } sideband_t;

    function automatic pixel888_t expand565(input pixel565_t p);
        pixel888_t q;
        q.r = {p.r, p.r[4:2]};
        q.g = {p.g, p.g[5:4]};
        q.b = {p.b, p.b[4:2]};
        return q;
    endfunction

endpackage

// File: rtl/fb_pixel_fetch_pipe_delay.sv
// Fixed-length register delay line with synchronous active-low clear.
module pipe_delay #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage[0] <= '0;
        end else begin
            stage[0] <= din;
        end
    end

    for (genvar g = 1; g < STAGES; g++) begin : g_stage
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                stage[g] <= '0;
            end else begin
                stage[g] <= stage[g-1];
            end
        end
    end

    assign dout = stage[STAGES-1];

endmodule

// File: rtl/fb_pixel_fetch.sv
// Forms the frame-buffer read address from scaled coordinates and re-aligns
// sync/blank/counters with the BRAM read data to produce an RGB888 stream.
module fb_pixel_fetch
    import fb_pkg::*;
#(
    parameter int unsigned FB_WIDTH     = 240,
    parameter int unsigned FB_HEIGHT    = 320,
    parameter int unsigned BRAM_LATENCY = 2,
    parameter logic [23:0] BORDER_RGB   = 24'h000000
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic [10:0]          hcount_in,
    input  logic [9:0]           vcount_in,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    input  logic                 active_draw_in,
    input  logic [10:0]          scaled_hcount_in,
    input  logic [9:0]           scaled_vcount_in,
    input  logic                 valid_addr_in,
    input  logic                 bank_sel_in,
    output logic [FB_ADDR_W:0]   fb_addr_out,
    input  logic [15:0]          fb_data_in,
    output logic [10:0]          hcount_out,
    output logic [9:0]           vcount_out,
    output logic                 hsync_out,
    output logic                 vsync_out,
    output logic                 active_draw_out,
    output logic [7:0]           red_out,
    output logic [7:0]           green_out,
    output logic [7:0]           blue_out,
    output logic                 frame_start_out,
    output logic [15:0]          frame_count_out
);

    if (BRAM_LATENCY < 1 || BRAM_LATENCY > 4) begin : g_bad_latency
        $error("fb_pixel_fetch: BRAM_LATENCY must be in 1..4");
    end
    if (FB_WIDTH * FB_HEIGHT > (1 << FB_ADDR_W)) begin : g_bad_size
        $error("fb_pixel_fetch: frame does not fit the 17-bit offset");
    end

    // Shift-add over the set bits of the constant stride, so only adders are built.
    function automatic logic [FB_ADDR_W-1:0] row_base(input logic [9:0] v);
        logic [FB_ADDR_W-1:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < FB_ADDR_W; i++) begin
            if (((FB_WIDTH >> i) & 32'd1) != 32'd0) begin
                acc = acc + ({{(FB_ADDR_W-10){1'b0}}, v} << i);
            end
        end
        return acc;
    endfunction

    logic                 vsync_prev;
    logic                 frame_edge;
    logic                 bank_q;
    logic [15:0]          frame_count;
    logic [FB_ADDR_W-1:0] offset;
    sideband_t            side_a;
    sideband_t            side_b;
    pixel888_t            px;

    assign frame_edge      = vsync_in & ~vsync_prev;
    assign frame_count_out = frame_count;
    assign offset          = row_base(scaled_vcount_in)
                           + {{(FB_ADDR_W-11){1'b0}}, scaled_hcount_in};

    // Edge detector follows vsync_in during reset, so a rise seen under reset never counts.
    always_ff @(posedge clk_in) begin
        vsync_prev <= vsync_in;
        if (!rst_n_in) begin
            bank_q      <= 1'b0;
            frame_count <= '0;
            fb_addr_out <= '0;
            side_a      <= '0;
        end else begin
            if (frame_edge) begin
                bank_q      <= bank_sel_in;
                frame_count <= frame_count + 16'd1;
            end
            fb_addr_out   <= {bank_q, valid_addr_in ? offset : '0};
            side_a.live   <= 1'b1;
            side_a.hcount <= hcount_in;
            side_a.vcount <= vcount_in;
            side_a.hsync  <= hsync_in;
            side_a.vsync  <= vsync_in;
            side_a.active <= active_draw_in;
            side_a.valid  <= valid_addr_in;
        end
    end

    pipe_delay #(
        .WIDTH  ($bits(sideband_t)),
        .STAGES (BRAM_LATENCY)
    ) u_side_delay (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .din   (side_a),
        .dout  (side_b)
    );

    pipe_delay #(
        .WIDTH  (1),
        .STAGES (BRAM_LATENCY + 2)
    ) u_frame_start_delay (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .din   (frame_edge),
        .dout  (frame_start_out)
    );

    assign px = expand565(fb_data_in);

    // Slots flushed by reset (live=0) output black rather than the border colour.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            hcount_out      <= '0;
            vcount_out      <= '0;
            hsync_out       <= 1'b0;
            vsync_out       <= 1'b0;
            active_draw_out <= 1'b0;
            red_out         <= '0;
            green_out       <= '0;
            blue_out        <= '0;
        end else begin
            hcount_out      <= side_b.hcount;
            vcount_out      <= side_b.vcount;
            hsync_out       <= side_b.hsync;
            vsync_out       <= side_b.vsync;
            active_draw_out <= side_b.active;
            if (!side_b.live) begin
                {red_out, green_out, blue_out} <= '0;
            end else if (side_b.valid && side_b.active) begin
                {red_out, green_out, blue_out} <= px;
            end else begin
                {red_out, green_out, blue_out} <= BORDER_RGB;
            end
        end
    end

endmodule

// File: tb/tb_fb_pixel_fetch.sv
// Directed bench for fb_pixel_fetch: default build plus BRAM_LATENCY=1 and =4 builds
// driven in parallel, each with its own BRAM model of matching latency.
module tb_fb_pixel_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hc, sh;
    logic [9:0]  vc, sv;
    logic        hs, vs, act, valid, bank;

    logic [17:0] addr0, addr1, addr4;
    logic [15:0] data0, data1, data4;
    logic [10:0] ho0, ho1, ho4;
    logic [9:0]  vo0, vo1, vo4;
    logic        hso0, hso1, hso4;
    logic        vso0, vso1, vso4;
    logic        ao0, ao1, ao4;
    logic [7:0]  r0, g0, b0, r1, g1, b1, r4, g4, b4;
    logic        fs0, fs1, fs4;
    logic [15:0] fc0, fc1, fc4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fb_pixel_fetch #(.BORDER_RGB(24'h123456)) dut0 (
        .clk_in(clk), .rst_n_in(rst_n), .hcount_in(hc), .vcount_in(vc),
        .hsync_in(hs), .vsync_in(vs), .active_draw_in(act),
        .scaled_hcount_in(sh), .scaled_vcount_in(sv), .valid_addr_in(valid),
        .bank_sel_in(bank), .fb_addr_out(addr0), .fb_data_in(data0),
        .hcount_out(ho0), .vcount_out(vo0), .hsync_out(hso0), .vsync_out(vso0),
        .active_draw_out(ao0), .red_out(r0), .green_out(g0), .blue_out(b0),
        .frame_start_out(fs0), .frame_count_out(fc0));

    fb_pixel_fetch #(.BRAM_LATENCY(1), .BORDER_RGB(24'h123456)) dut1 (
        .clk_in(clk), .rst_n_in(rst_n), .hcount_in(hc), .vcount_in(vc),
        .hsync_in(hs), .vsync_in(vs), .active_draw_in(act),
        .scaled_hcount_in(sh), .scaled_vcount_in(sv), .valid_addr_in(valid),
        .bank_sel_in(bank), .fb_addr_out(addr1), .fb_data_in(data1),
        .hcount_out(ho1), .vcount_out(vo1), .hsync_out(hso1), .vsync_out(vso1),
        .active_draw_out(ao1), .red_out(r1), .green_out(g1), .blue_out(b1),
        .frame_start_out(fs1), .frame_count_out(fc1));

    fb_pixel_fetch #(.BRAM_LATENCY(4), .BORDER_RGB(24'h123456)) dut4 (
        .clk_in(clk), .rst_n_in(rst_n), .hcount_in(hc), .vcount_in(vc),
        .hsync_in(hs), .vsync_in(vs), .active_draw_in(act),
        .scaled_hcount_in(sh), .scaled_vcount_in(sv), .valid_addr_in(valid),
        .bank_sel_in(bank), .fb_addr_out(addr4), .fb_data_in(data4),
        .hcount_out(ho4), .vcount_out(vo4), .hsync_out(hso4), .vsync_out(vso4),
        .active_draw_out(ao4), .red_out(r4), .green_out(g4), .blue_out(b4),
        .frame_start_out(fs4), .frame_count_out(fc4));

    // Frame-buffer contents: a few hand-picked words, everything else all-ones.
    function automatic logic [15:0] bram_word(input logic [17:0] a);
        case (a[16:0])
            17'd730:   return 16'hF800;
            17'd76799: return 16'h07E0;
            17'd1000:  return 16'h8410;
            default:   return 16'hFFFF;
        endcase
    endfunction

    logic [15:0] m0 [2];
    logic [15:0] m1;
    logic [15:0] m4 [4];

    always @(posedge clk) begin
        m0[0] <= bram_word(addr0);
        m0[1] <= m0[0];
        m1    <= bram_word(addr1);
        m4[0] <= bram_word(addr4);
        for (int i = 1; i < 4; i++) m4[i] <= m4[i-1];
    end

    assign data0 = m0[1];
    assign data1 = m1;
    assign data4 = m4[3];

    logic mon_en = 1'b0;
    logic vp0 = 1'b0, vp1 = 1'b0, vp4 = 1'b0;
    int fs_cnt0 = 0, fs_cnt1 = 0, fs_cnt4 = 0;
    int mis0 = 0, mis1 = 0, mis4 = 0;

    // frame_start pulse count and its coincidence with vsync_out rising.
    always @(negedge clk) begin
        if (mon_en) begin
            if (fs0) fs_cnt0 <= fs_cnt0 + 1;
            if (fs1) fs_cnt1 <= fs_cnt1 + 1;
            if (fs4) fs_cnt4 <= fs_cnt4 + 1;
            if (fs0 !== (vso0 & ~vp0)) mis0 <= mis0 + 1;
            if (fs1 !== (vso1 & ~vp1)) mis1 <= mis1 + 1;
            if (fs4 !== (vso4 & ~vp4)) mis4 <= mis4 + 1;
        end
        vp0 <= vso0;
        vp1 <= vso1;
        vp4 <= vso4;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pix(input logic [10:0] h, input logic [9:0] v, input logic va,
                       input logic ac, input logic [10:0] rawh, input logic [9:0] rawv);
        sh = h; sv = v; valid = va; act = ac; hc = rawh; vc = rawv;
    endtask

    initial begin
        rst_n = 1'b0; hs = 1'b0; vs = 1'b0; bank = 1'b0;
        pix(11'd0, 10'd0, 1'b0, 1'b0, 11'd0, 10'd0);

        // reset state, and a vsync rise under reset
        step(2);
        chk("rst_addr", 32'(addr0), 32'd0);
        chk("rst_rgb", 32'({r0, g0, b0}), 32'd0);
        chk("rst_count", 32'(fc0), 32'd0);
        chk("rst_fs", 32'(fs0), 32'd0);
        chk("rst_hcount", 32'(ho0), 32'd0);
        vs = 1'b1;
        step(1);
        rst_n = 1'b1;
        step(3);
        chk("rst_edge_ignored", 32'(fc0), 32'd0);
        vs = 1'b0;
        step(6);

        // single pixel (10,3) -> 730, latency per build
        pix(11'd10, 10'd3, 1'b1, 1'b1, 11'd100, 10'd50);
        hs = 1'b1;
        step(1);
        chk("addr_730_l2", 32'(addr0), 32'd730);
        chk("addr_730_l1", 32'(addr1), 32'd730);
        chk("addr_730_l4", 32'(addr4), 32'd730);
        pix(11'd0, 10'd0, 1'b0, 1'b0, 11'd0, 10'd0);
        hs = 1'b0;
        step(1);
        chk("l1_s2_border", 32'(r1), 32'h12);
        step(1);
        chk("l1_s3_red", 32'({r1, g1, b1}), 32'hFF0000);
        chk("l1_s3_hcount", 32'(ho1), 32'd100);
        chk("l1_s3_hsync", 32'(hso1), 32'd1);
        chk("l2_s3_border", 32'(r0), 32'h12);
        step(1);
        chk("l2_s4_rgb", 32'({r0, g0, b0}), 32'hFF0000);
        chk("l2_s4_hcount", 32'(ho0), 32'd100);
        chk("l2_s4_vcount", 32'(vo0), 32'd50);
        chk("l2_s4_hsync", 32'(hso0), 32'd1);
        chk("l2_s4_active", 32'(ao0), 32'd1);
        step(1);
        chk("l4_s5_border", 32'(r4), 32'h12);
        chk("l2_s5_border", 32'({r0, g0, b0}), 32'h123456);
        step(1);
        chk("l4_s6_rgb", 32'({r4, g4, b4}), 32'hFF0000);
        chk("l4_s6_hcount", 32'(ho4), 32'd100);
        chk("l4_s6_hsync", 32'(hso4), 32'd1);
        step(2);

        // last pixel, replication pattern, invalid and inactive gating
        pix(11'd239, 10'd319, 1'b1, 1'b1, 11'd200, 10'd60);
        step(1);
        chk("addr_last", 32'(addr0), 32'd76799);
        pix(11'd40, 10'd4, 1'b1, 1'b1, 11'd201, 10'd60);
        step(1);
        chk("addr_1000", 32'(addr0), 32'd1000);
        pix(11'd500, 10'd3, 1'b0, 1'b1, 11'd202, 10'd60);
        step(1);
        chk("addr_invalid", 32'(addr0), 32'd0);
        pix(11'd10, 10'd3, 1'b1, 1'b0, 11'd203, 10'd60);
        step(1);
        chk("rgb_green", 32'({r0, g0, b0}), 32'h00FF00);
        pix(11'd0, 10'd0, 1'b0, 1'b0, 11'd0, 10'd0);
        step(1);
        chk("rgb_expand", 32'({r0, g0, b0}), 32'h848284);
        step(1);
        chk("rgb_invalid_border", 32'({r0, g0, b0}), 32'h123456);
        chk("invalid_active", 32'(ao0), 32'd1);
        chk("invalid_hcount", 32'(ho0), 32'd202);
        step(1);
        chk("rgb_inactive_border", 32'({r0, g0, b0}), 32'h123456);
        chk("inactive_active", 32'(ao0), 32'd0);

        // bank latched only on vsync rise
        pix(11'd10, 10'd3, 1'b1, 1'b1, 11'd5, 10'd5);
        bank = 1'b1;
        step(1);
        chk("bank_hold", 32'(addr0), 32'd730);
        vs = 1'b1;
        step(1);
        chk("bank_edge_cycle", 32'(addr0), 32'd730);
        step(1);
        chk("bank_switched", 32'(addr0), 32'd131802);
        bank = 1'b0;
        step(3);
        chk("bank_midframe", 32'(addr0), 32'd131802);
        chk("first_frame", 32'(fc0), 32'd1);
        vs = 1'b0;
        step(1);
        vs = 1'b1;
        step(2);
        chk("bank_back", 32'(addr0), 32'd730);
        chk("second_frame", 32'(fc0), 32'd2);

        // four frames, pulse count and alignment in all builds
        vs = 1'b0;
        pix(11'd0, 10'd0, 1'b0, 1'b0, 11'd0, 10'd0);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(6);
        mon_en = 1'b1;
        for (int unsigned k = 1; k <= 4; k++) begin
            vs = 1'b1;
            step(1);
            chk("frame_count_edge", 32'(fc0), 32'(k));
            step(4);
            chk("frame_count_held", 32'(fc0), 32'(k));
            vs = 1'b0;
            step(5);
        end
        step(8);
        mon_en = 1'b0;
        chk("fs_pulses_l2", 32'(fs_cnt0), 32'd4);
        chk("fs_pulses_l1", 32'(fs_cnt1), 32'd4);
        chk("fs_pulses_l4", 32'(fs_cnt4), 32'd4);
        chk("fs_align_l2", 32'(mis0), 32'd0);
        chk("fs_align_l1", 32'(mis1), 32'd0);
        chk("fs_align_l4", 32'(mis4), 32'd0);

        // counter wrap
        force dut0.frame_count = 16'hFFFF;
        #1;
        release dut0.frame_count;
        chk("count_preload", 32'(fc0), 32'hFFFF);
        vs = 1'b1;
        step(1);
        chk("count_wrap", 32'(fc0), 32'd0);

        // reset with a full pipeline
        vs = 1'b0;
        bank = 1'b1;
        step(1);
        vs = 1'b1;
        step(1);
        chk("pre_rst_count", 32'(fc0), 32'd1);
        pix(11'd10, 10'd3, 1'b1, 1'b1, 11'd60, 10'd60);
        step(3);
        chk("pre_rst_addr", 32'(addr0), 32'd131802);
        rst_n = 1'b0;
        step(1);
        chk("flush_addr", 32'(addr0), 32'd0);
        chk("flush_rgb", 32'({r0, g0, b0}), 32'd0);
        chk("flush_hcount", 32'(ho0), 32'd0);
        chk("flush_active", 32'(ao0), 32'd0);
        chk("flush_vsync", 32'(vso0), 32'd0);
        chk("flush_count", 32'(fc0), 32'd0);
        chk("flush_fs", 32'(fs0), 32'd0);
        rst_n = 1'b1;
        vs = 1'b0;
        pix(11'd10, 10'd3, 1'b1, 1'b1, 11'd77, 10'd60);
        step(1);
        chk("resume_addr_bank0", 32'(addr0), 32'd730);
        pix(11'd0, 10'd0, 1'b0, 1'b0, 11'd0, 10'd0);
        step(1);
        chk("resume_s2_black", 32'({r0, g0, b0}), 32'd0);
        step(1);
        chk("resume_s3_black", 32'({r0, g0, b0}), 32'd0);
        step(1);
        chk("resume_s4_rgb", 32'({r0, g0, b0}), 32'hFF0000);
        chk("resume_s4_hcount", 32'(ho0), 32'd77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
